// File: rtl/surf_command_framer.sv
// Frames runcmd, trigger and firmware streams into one 32-bit command word per PERIOD cycles.
// Optional SURF_CMD_PARITY_EN: odd parity in bit [0], sequence shrinks to 2 bits in [2:1].
module surf_command_framer #(
    parameter int unsigned PERIOD        = 8,
    parameter int unsigned RUNCMD_BITS   = 2,
    parameter int unsigned TRIG_BITS     = 15,
    parameter logic [31:0] TRAIN_PATTERN = 32'hA55A3CC3
) (
    input  logic                   sysclk_i,
    input  logic                   sysclk_rstn_i,
    input  logic                   enable_i,
    input  logic                   train_i,
    input  logic [RUNCMD_BITS-1:0] runcmd_tdata,
    input  logic                   runcmd_tvalid,
    output logic                   runcmd_tready,
    input  logic [TRIG_BITS-1:0]   trig_tdata,
    input  logic                   trig_tvalid,
    output logic                   trig_tready,
    input  logic [7:0]             fw_tdata,
    input  logic                   fw_tvalid,
    output logic                   fw_tready,
    input  logic [1:0]             fw_mark_i,
    output logic                   fw_marked_o,
    output logic                   sync_o,
    output logic [31:0]            cmd_o,
    output logic                   cmd_load_o
);

    localparam int unsigned PW = $clog2(PERIOD);

`ifdef SURF_CMD_PARITY_EN
    localparam int unsigned SEQ_W = 2;
`else
    localparam int unsigned SEQ_W = 3;
`endif

    localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PH_CAP  = PW'(PERIOD - 2);
    localparam logic [PW-1:0] PH_PRE  = PW'(PERIOD - 3);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StTrain
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          phase_q;
    logic [SEQ_W-1:0]       seq_q, seq_d;

    logic [RUNCMD_BITS-1:0] rc_q;
    logic                   trig_v_q;
    logic [TRIG_BITS-1:0]   trig_q;
    logic                   fw_v_q;
    logic [7:0]             fw_q;
    logic [1:0]             mark_q;

    logic                   ready_q;
    logic                   sync_q;
    logic                   load_q;
    logic                   marked_q;
    logic [31:0]            cmd_q;

    logic                   at_last;
    logic                   rc_take, trig_take, fw_take;
    logic [31:0]            run_word;
    logic [31:0]            word_d;

    always_comb begin
        at_last   = (phase_q == PH_LAST);
        rc_take   = ready_q && runcmd_tvalid;
        trig_take = ready_q && trig_tvalid;
        fw_take   = ready_q && fw_tvalid;

        // Train wins over enable; otherwise enable alone picks RUN vs IDLE.
        if (train_i) begin
            state_d = StTrain;
        end else if (enable_i) begin
            state_d = StRun;
        end else begin
            state_d = StIdle;
        end

        if (state_q == StIdle && state_d == StRun) begin
            seq_d = '0;
        end else if (state_q == StRun) begin
            seq_d = seq_q + SEQ_W'(1);
        end else begin
            seq_d = seq_q;
        end

`ifdef SURF_CMD_PARITY_EN
        run_word    = {rc_q, trig_v_q, trig_q, fw_v_q, fw_q, mark_q, seq_q, 1'b0};
        run_word[0] = ~(^run_word[31:1]);
`else
        run_word = {rc_q, trig_v_q, trig_q, fw_v_q, fw_q, mark_q, seq_q};
`endif

        unique case (state_q)
            StRun:   word_d = run_word;
            StTrain: word_d = TRAIN_PATTERN;
            default: word_d = 32'h0;
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            seq_q    <= '0;
            rc_q     <= '0;
            trig_v_q <= 1'b0;
            trig_q   <= '0;
            fw_v_q   <= 1'b0;
            fw_q     <= '0;
            mark_q   <= '0;
            ready_q  <= 1'b0;
            sync_q   <= 1'b0;
            load_q   <= 1'b0;
            marked_q <= 1'b0;
            cmd_q    <= '0;
        end else begin
            phase_q  <= at_last ? '0 : phase_q + PW'(1);
            // Registered so tready is high exactly during the PERIOD-2 cycle.
            ready_q  <= (state_q == StRun) && (phase_q == PH_PRE);
            sync_q   <= at_last;
            load_q   <= at_last;
            marked_q <= at_last && (state_q == StRun) && (mark_q != 2'b00);

            if (phase_q == PH_CAP) begin
                rc_q     <= rc_take ? runcmd_tdata : '0;
                trig_v_q <= trig_take;
                trig_q   <= trig_take ? trig_tdata : '0;
                fw_v_q   <= fw_take;
                fw_q     <= fw_take ? fw_tdata : '0;
                mark_q   <= fw_take ? fw_mark_i : 2'b00;
            end

            if (at_last) begin
                cmd_q   <= word_d;
                state_q <= state_d;
                seq_q   <= seq_d;
            end
        end
    end

    assign runcmd_tready = ready_q;
    assign trig_tready   = ready_q;
    assign fw_tready     = ready_q;
    assign sync_o        = sync_q;
    assign cmd_load_o    = load_q;
    assign fw_marked_o   = marked_q;
    assign cmd_o         = cmd_q;

endmodule
